// File: rtl/variable_delay_buffer_if.sv
// Stream port bundle of the runtime-programmable delay line: control, input sample,
// delayed output sample and its valid flag.
interface variable_delay_buffer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) ();
  logic              run;
  logic [ADDR_W-1:0] amount;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] out0;
  logic              valid;

  modport master (
    output run,
    output amount,
    output in0,
    input  out0,
    input  valid
  );

  modport slave (
    input  run,
    input  amount,
    input  in0,
    output out0,
    output valid
  );
endinterface

// File: rtl/variable_delay_buffer.sv
// Runtime-programmable delay line: circular register array with write/read pointers,
// delay latched on run, registered output with a valid flag.
module variable_delay_buffer #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  variable_delay_buffer_if.slave bus
);

  localparam logic [ADDR_W-1:0] One = ADDR_W'(1);

  typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] amount_q, amount_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // With amount_q >= 1 the read slot was written amount_q cycles ago and is never the
  // slot being written this cycle.
  assign rd_addr = wr_ptr_q - amount_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    amount_d   = amount_q;
    fill_cnt_d = fill_cnt_q;
    out_d      = '0;
    valid_d    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr_q;

    if (bus.run) begin
      // Restart from any state: run-cycle sample goes to slot 0, fill count holds
      // the number of samples written since run.
      amount_d   = bus.amount;
      wr_en      = 1'b1;
      wr_addr    = '0;
      wr_ptr_d   = One;
      fill_cnt_d = One;
      if (bus.amount == '0) begin
        state_d = StStream;
        out_d   = bus.in0;
        valid_d = 1'b1;
      end else begin
        state_d = StFill;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StFill: begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + One;
          if (fill_cnt_q >= amount_q) begin
            state_d = StStream;
            out_d   = mem[rd_addr];
            valid_d = 1'b1;
          end else begin
            fill_cnt_d = fill_cnt_q + One;
          end
        end
        StStream: begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + One;
          valid_d  = 1'b1;
          out_d    = (amount_q == '0) ? bus.in0 : mem[rd_addr];
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      amount_q   <= '0;
      fill_cnt_q <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      amount_q   <= amount_d;
      fill_cnt_q <= fill_cnt_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
    end
  end

  // Storage array carries no reset; stale slots are masked by the fill logic.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.in0;
    end
  end

  assign bus.out0  = out_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_variable_delay_buffer.sv
// Directed plus randomized bench for variable_delay_buffer; expectations come from a
// per-cycle input history and the last run time/amount.
module tb_variable_delay_buffer;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int HistLen = 4096;

  logic clk = 1'b0;
  logic rst;

  variable_delay_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  variable_delay_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: sample history by cycle, plus the latest run (if any since reset).
  logic [DATA_W-1:0] hist [HistLen];
  int cyc    = 0;
  bit active = 1'b0;
  int t_run  = 0;
  int a_run  = 0;

  task automatic compare(input string tag, input logic [DATA_W-1:0] exp_d, input logic exp_v);
    total++;
    assert (bus.valid === exp_v) else begin
      bad++;
      $error("FAIL %s cyc=%0d valid: got %b want %b", tag, cyc, bus.valid, exp_v);
    end
    total++;
    assert (bus.out0 === exp_d) else begin
      bad++;
      $error("FAIL %s cyc=%0d out0: got %h want %h", tag, cyc, bus.out0, exp_d);
    end
  endtask

  // Output seen now is the sample from cycle (cyc-1-amount), valid only if not before run.
  task automatic check_model(input string tag);
    logic [DATA_W-1:0] exp_d;
    logic exp_v;
    int k;
    exp_d = '0;
    exp_v = 1'b0;
    if (active) begin
      k = cyc - 1 - a_run;
      if (k >= t_run) begin
        exp_v = 1'b1;
        exp_d = hist[k];
      end
    end
    compare(tag, exp_d, exp_v);
  endtask

  task automatic tick(input string tag, input logic r, input logic [ADDR_W-1:0] amt,
                      input logic [DATA_W-1:0] d);
    bus.run    = r;
    bus.amount = amt;
    bus.in0    = d;
    @(posedge clk);
    if (cyc >= HistLen) begin
      bad++;
      $display("FAIL history overflow cyc=%0d", cyc);
      $fatal(1, "history overflow");
    end
    hist[cyc] = d;
    if (r) begin
      active = 1'b1;
      t_run  = cyc;
      a_run  = int'(amt);
    end
    cyc++;
    #1;
    check_model(tag);
  endtask

  // Assert rst between edges and check the outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 compare(tag, '0, 1'b0);
    active = 1'b0;
    #1 rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    bus.run    = 1'b0;
    bus.amount = '0;
    bus.in0    = '0;
    #2 compare("reset", '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Idle without run: nothing appears
    for (int i = 0; i < 3; i++) tick("idle", 1'b0, 6'd4, 32'hdead0000 + i);

    // Pure 1-cycle register
    tick("amt0_run", 1'b1, 6'd0, 32'd10);
    for (int i = 1; i < 6; i++) tick("amt0", 1'b0, 6'd0, 32'(10 + i));

    // Delay 5
    tick("amt5_run", 1'b1, 6'd5, 32'd100);
    for (int i = 1; i < 12; i++) tick("amt5", 1'b0, 6'd5, 32'(100 + i));

    // Maximum delay across pointer wrap
    tick("amt63_run", 1'b1, 6'd63, 32'd0);
    for (int i = 1; i < 300; i++) tick("amt63", 1'b0, 6'd63, 32'(i));

    // Restart while streaming with a shorter delay
    tick("rerun_a", 1'b1, 6'd5, $urandom);
    for (int i = 0; i < 49; i++) tick("rerun_a", 1'b0, 6'd5, $urandom);
    tick("rerun_b", 1'b1, 6'd3, $urandom);
    for (int i = 0; i < 20; i++) tick("rerun_b", 1'b0, 6'd3, $urandom);

    // Async reset mid-FILL, then no activity until run
    tick("rst_fill", 1'b1, 6'd20, $urandom);
    for (int i = 0; i < 10; i++) tick("rst_fill", 1'b0, 6'd20, $urandom);
    async_reset("rst_fill_async");
    for (int i = 0; i < 10; i++) tick("post_rst", 1'b0, 6'd20, $urandom);

    // Async reset mid-STREAM clears a nonzero output
    tick("rst_strm", 1'b1, 6'd2, 32'hffff_0000);
    for (int i = 0; i < 10; i++) tick("rst_strm", 1'b0, 6'd2, 32'hffff_0001 + i);
    async_reset("rst_strm_async");
    for (int i = 0; i < 5; i++) tick("post_rst2", 1'b0, 6'd2, $urandom);

    // amount changes without run are ignored
    tick("amt_chg", 1'b1, 6'd5, $urandom);
    for (int i = 0; i < 20; i++) tick("amt_chg", 1'b0, 6'd5, $urandom);
    for (int i = 0; i < 20; i++) tick("amt_chg9", 1'b0, 6'd9, $urandom);

    // Random runs, amounts and data
    for (int i = 0; i < 900; i++) begin
      tick("random", ($urandom_range(0, 39) == 0), 6'($urandom_range(0, 63)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
